// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, start-bit validation, mid-bit sampling.
// Done_o / FrameError_o are single-cycle strobes; Data_o holds the last good byte.
module uart_rx #(
  parameter int unsigned CLOCK_HZ = 10_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Rx_i,
  output logic [7:0] Data_o,
  output logic       Done_o,
  output logic       Busy_o,
  output logic       FrameError_o
);

  localparam int unsigned TICKS = CLOCK_HZ / BAUD;
  localparam int unsigned HALF  = TICKS / 2;
  localparam int unsigned CW    = $clog2(TICKS) + 1;

  localparam logic [CW-1:0] HALF_LOAD = CW'(HALF - 1);
  localparam logic [CW-1:0] TICK_LOAD = CW'(TICKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  logic [1:0]    sync;
  logic          rx_sync;
  logic [CW-1:0] timer;
  logic [2:0]    idx;
  logic [7:0]    shreg;

  assign rx_sync = sync[1];

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sync         <= 2'b11;
      state        <= IDLE;
      timer        <= '0;
      idx          <= '0;
      shreg        <= '0;
      Data_o       <= '0;
      Done_o       <= 1'b0;
      Busy_o       <= 1'b0;
      FrameError_o <= 1'b0;
    end else begin
      sync         <= {sync[0], Rx_i};
      Done_o       <= 1'b0;
      FrameError_o <= 1'b0;

      case (state)
        IDLE: begin
          Busy_o <= 1'b0;
          if (!rx_sync) begin
            timer  <= HALF_LOAD;
            Busy_o <= 1'b1;
            state  <= START;
          end
        end

        START: begin
          if (timer == '0) begin
            if (!rx_sync) begin
              timer <= TICK_LOAD;
              idx   <= '0;
              state <= DATA;
            end else begin
              // Start bit did not survive to mid-bit: treat as a glitch.
              Busy_o <= 1'b0;
              state  <= IDLE;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end

        DATA: begin
          if (timer == '0) begin
            shreg <= {rx_sync, shreg[7:1]};
            timer <= TICK_LOAD;
            idx   <= idx + 3'd1;
            if (idx == 3'd7) state <= STOP;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        STOP: begin
          if (timer == '0) begin
            if (rx_sync) begin
              Data_o <= shreg;
              Done_o <= 1'b1;
            end else begin
              FrameError_o <= 1'b1;
            end
            Busy_o <= 1'b0;
            state  <= IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        default: begin
          Busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 MHz / 115200 baud (86 clocks per bit).
`timescale 1ns/1ps
module tb_uart_rx;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       Rx_i  = 1'b1;
  logic [7:0] Data_o;
  logic       Done_o;
  logic       Busy_o;
  logic       FrameError_o;

  int checks = 0;
  int errors = 0;

  int cyc       = 0;
  int done_cnt  = 0;
  int fe_cnt    = 0;
  int both_cnt  = 0;
  int busy_cyc  = 0;
  int last_done_cyc = 0;
  int last_start    = 0;
  logic [7:0] dlog[$];

  always #50 Clock = ~Clock;

  uart_rx #(.CLOCK_HZ(10_000_000), .BAUD(115200)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Rx_i         (Rx_i),
    .Data_o       (Data_o),
    .Done_o       (Done_o),
    .Busy_o       (Busy_o),
    .FrameError_o (FrameError_o)
  );

  always @(posedge Clock) cyc <= cyc + 1;

  always @(negedge Clock) begin
    if (Reset) begin
      if (Done_o) begin
        done_cnt      <= done_cnt + 1;
        last_done_cyc <= cyc;
        dlog.push_back(Data_o);
      end
      if (FrameError_o) fe_cnt <= fe_cnt + 1;
      if (Done_o && FrameError_o) both_cnt <= both_cnt + 1;
      if (Busy_o) busy_cyc <= busy_cyc + 1;
    end
  end

  // Caller is at a negedge; the task also returns at a negedge with the line idle.
  task automatic send_frame(input logic [7:0] b, input int bclk, input logic stopb);
    Rx_i = 1'b0;
    last_start = cyc;
    repeat (bclk) @(negedge Clock);
    for (int i = 0; i < 8; i++) begin
      Rx_i = b[i];
      repeat (bclk) @(negedge Clock);
    end
    Rx_i = stopb;
    repeat (bclk) @(negedge Clock);
    Rx_i = 1'b1;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    Rx_i  = 1'b1;
    repeat (4) @(negedge Clock);
    checks++;
    if (Data_o !== 8'h00 || Done_o !== 1'b0 || Busy_o !== 1'b0 || FrameError_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: data=%h done=%b busy=%b fe=%b, want 00 0 0 0",
               Data_o, Done_o, Busy_o, FrameError_o);
    end
    Reset = 1'b1;
    repeat (10) @(negedge Clock);
    checks++;
    if (Busy_o !== 1'b0 || done_cnt != 0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done_cnt=%0d, want 0 0", Busy_o, done_cnt);
    end
  endtask

  task automatic test_single_frame();
    int d0, b0, f0, lat;
    d0 = done_cnt; b0 = busy_cyc; f0 = fe_cnt;
    send_frame(8'hF0, 86, 1'b1);
    repeat (50) @(negedge Clock);
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL f0_done_count: got %0d pulses, want 1", done_cnt - d0);
    end
    checks++;
    if (Data_o !== 8'hF0) begin
      errors++;
      $display("FAIL f0_data: got %h, want f0", Data_o);
    end
    checks++;
    if (fe_cnt != f0) begin
      errors++;
      $display("FAIL f0_no_fe: got %0d frame errors, want 0", fe_cnt - f0);
    end
    lat = last_done_cyc - last_start;
    checks++;
    if (lat < 818 || lat > 820) begin
      errors++;
      $display("FAIL f0_latency: got %0d clocks, want 819 +/-1", lat);
    end
    checks++;
    if (busy_cyc - b0 < 812 || busy_cyc - b0 > 820) begin
      errors++;
      $display("FAIL f0_busy_span: busy for %0d clocks, want about 817", busy_cyc - b0);
    end
  endtask

  task automatic test_back_to_back();
    int d0, n0;
    d0 = done_cnt; n0 = dlog.size();
    send_frame(8'hF0, 86, 1'b1);
    send_frame(8'h31, 86, 1'b1);
    repeat (50) @(negedge Clock);
    checks++;
    if (done_cnt - d0 != 2 || dlog.size() - n0 != 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d pulses, want 2", done_cnt - d0);
    end else begin
      checks++;
      if (dlog[n0] !== 8'hF0 || dlog[n0+1] !== 8'h31) begin
        errors++;
        $display("FAIL b2b_data: got %h %h, want f0 31", dlog[n0], dlog[n0+1]);
      end
    end
  endtask

  task automatic test_glitch();
    int d0, f0, b0;
    d0 = done_cnt; f0 = fe_cnt; b0 = busy_cyc;
    Rx_i = 1'b0;
    repeat (20) @(negedge Clock);
    Rx_i = 1'b1;
    repeat (100) @(negedge Clock);
    checks++;
    if (busy_cyc - b0 < 42 || busy_cyc - b0 > 44) begin
      errors++;
      $display("FAIL glitch_busy: busy for %0d clocks, want 43 +/-1", busy_cyc - b0);
    end
    checks++;
    if (done_cnt != d0 || fe_cnt != f0 || Busy_o !== 1'b0) begin
      errors++;
      $display("FAIL glitch_silent: done=%0d fe=%0d busy=%b, want 0 0 0",
               done_cnt - d0, fe_cnt - f0, Busy_o);
    end
    checks++;
    if (Data_o !== 8'h31) begin
      errors++;
      $display("FAIL glitch_data_hold: got %h, want 31", Data_o);
    end
  endtask

  task automatic test_frame_error();
    int d0, f0;
    d0 = done_cnt; f0 = fe_cnt;
    send_frame(8'h55, 86, 1'b0);
    repeat (150) @(negedge Clock);
    checks++;
    if (fe_cnt - f0 != 1 || done_cnt != d0) begin
      errors++;
      $display("FAIL ferr_strobe: fe=%0d done=%0d, want 1 0", fe_cnt - f0, done_cnt - d0);
    end
    checks++;
    if (Data_o !== 8'h31) begin
      errors++;
      $display("FAIL ferr_data_hold: got %h, want 31", Data_o);
    end
    send_frame(8'hA5, 86, 1'b1);
    repeat (50) @(negedge Clock);
    checks++;
    if (Data_o !== 8'hA5 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL ferr_recover: data=%h done=%0d, want a5 1", Data_o, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int d0, f0;
    logic [7:0] b;
    b = 8'h3C;
    Rx_i = 1'b0;
    repeat (86) @(negedge Clock);
    for (int i = 0; i < 4; i++) begin
      Rx_i = b[i];
      repeat (86) @(negedge Clock);
    end
    checks++;
    if (Busy_o !== 1'b1) begin
      errors++;
      $display("FAIL midrst_busy_before: got %b, want 1", Busy_o);
    end
    #10 Reset = 1'b0;
    #1;
    checks++;
    if (Busy_o !== 1'b0 || Data_o !== 8'h00 || Done_o !== 1'b0 || FrameError_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: busy=%b data=%h done=%b fe=%b, want 0 00 0 0",
               Busy_o, Data_o, Done_o, FrameError_o);
    end
    Rx_i = 1'b1;
    repeat (20) @(negedge Clock);
    Reset = 1'b1;
    d0 = done_cnt; f0 = fe_cnt;
    repeat (900) @(negedge Clock);
    checks++;
    if (done_cnt != d0 || fe_cnt != f0 || Data_o !== 8'h00) begin
      errors++;
      $display("FAIL midrst_no_strobe: done=%0d fe=%0d data=%h, want 0 0 00",
               done_cnt - d0, fe_cnt - f0, Data_o);
    end
    send_frame(8'h3C, 86, 1'b1);
    repeat (50) @(negedge Clock);
    checks++;
    if (Data_o !== 8'h3C || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL midrst_recover: data=%h done=%0d, want 3c 1", Data_o, done_cnt - d0);
    end
  endtask

  task automatic test_baud_tolerance();
    logic [7:0] vals [4];
    int         bclk [4];
    int d0, f0;
    vals = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    bclk = '{89, 83, 83, 89};
    for (int k = 0; k < 4; k++) begin
      d0 = done_cnt; f0 = fe_cnt;
      send_frame(vals[k], bclk[k], 1'b1);
      repeat (60) @(negedge Clock);
      checks++;
      if (Data_o !== vals[k] || done_cnt - d0 != 1 || fe_cnt != f0) begin
        errors++;
        $display("FAIL tol_%0d_bclk%0d: data=%h done=%0d fe=%0d, want %h 1 0",
                 k, bclk[k], Data_o, done_cnt - d0, fe_cnt - f0, vals[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_mid_frame();
    test_baud_tolerance();
    checks++;
    if (both_cnt != 0) begin
      errors++;
      $display("FAIL done_fe_exclusive: %0d overlapping cycles, want 0", both_cnt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20_000_000;
    $display("FAIL timeout: bench did not finish, limit 20 ms");
    $fatal(1);
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the counterpart of the team's UART_TX, and shares its CLOCK_HZ/BAUD parameterisation.
- Synchronises the asynchronous Rx line, detects and validates the start bit, and samples each bit at mid-bit.
- Delivers each received byte with a one-cycle Done_o strobe.
- Sits between the board Rx pin and any byte consumer (command parser, FIFO, loopback test against UART_TX).

Parameters:
CLOCK_HZ  10_000_000  system clock frequency in Hz
BAUD  115200  line rate in bit/s; TICKS = CLOCK_HZ/BAUD (integer division, 86 at defaults), HALF = TICKS/2 (43)

Ports:
Clock  in  1  system clock, all logic on rising edge
Reset  in  1  asynchronous, active-low reset
Rx_i  in  1  serial input, asynchronous to Clock, idle high
Data_o  out  8  last correctly received byte, LSB = first data bit
Done_o  out  1  one-cycle strobe: Data_o just updated with a valid frame
Busy_o  out  1  high while a frame is being received
FrameError_o  out  1  one-cycle strobe: stop bit sampled low

Behaviour:
- Reset (Reset=0): Data_o=8'h00, Done_o=0, Busy_o=0, FrameError_o=0, both synchroniser flops=1, state=IDLE, counters=0.
- Reset is asynchronous: asserting it mid-frame aborts the frame immediately; no Done_o or FrameError_o is produced.
- Synchroniser: two flops on Rx_i. All decisions use RxSync, which lags Rx_i by 2 clocks.
- Bit timer: down-counter, width clog2(TICKS)+1. A sample occurs when the counter reaches 0.
- IDLE:
  - Busy_o=0.
  - When RxSync==0, load the timer with HALF-1 and go to START.
- START:
  - Busy_o=1.
  - At the sample, if RxSync==0: load TICKS-1, clear the bit index, go to DATA.
  - If RxSync==1 at the sample (glitch/false start): return to IDLE silently, with no strobe.
- DATA:
  - At each sample, shift RxSync into the shift register from the MSB side (LSB-first line order) and reload TICKS-1.
  - After the 8th sample, go to STOP.
  - The 3-bit index wraps only via the state exit.
- STOP:
  - At the sample, if RxSync==1: Data_o<=shift register and Done_o=1 for exactly one cycle.
  - If RxSync==0: FrameError_o=1 for one cycle, Data_o unchanged, no Done_o.
  - Next state is IDLE (same edge) in both cases.
  - If the line is still low after a framing error, IDLE treats it as a new start; a break therefore produces repeated FrameError_o strobes, which is accepted.
- Busy_o deasserts on the same edge Done_o/FrameError_o asserts.
- Latency: Done_o asserts 2 + HALF + 9*TICKS clocks after the Rx_i falling edge (±1). At defaults this is 2+43+774 = 819 clocks. The receiver then sits in IDLE for about half a bit, so back-to-back frames with a single stop bit are received without loss.
- Done_o and FrameError_o are never high in the same cycle.
- Data_o holds its value between frames.
- Tolerance: accumulated sample drift over 9.5 bits must stay within ±1/2 bit, giving roughly ±4% combined clock/baud error at defaults.

Test Plan:
1. Drive an 8N1 frame 8'hF0 at 115200 baud (10 MHz clock) after releasing reset -> exactly one Done_o pulse about 819 clocks after the start edge; Data_o=8'hF0; FrameError_o stays 0; Busy_o high for the whole frame.
2. Back-to-back frames 8'hF0 then 8'h31, second start bit immediately after the first stop bit (can be sourced from a UART_TX instance in loopback) -> two Done_o pulses, Data_o=8'hF0 then 8'h31, no missed frame.
3. Rx_i low pulse of 20 clocks, then high -> Busy_o pulses about 43 clocks, then IDLE; no Done_o, no FrameError_o, Data_o unchanged.
4. Frame 8'h55 with stop bit forced to 0 -> one FrameError_o pulse, no Done_o, Data_o keeps its previous value; next valid frame 8'hA5 is received correctly.
5. Assert Reset mid-byte (after bit 3 of 8'h3C) and release while the line is idle -> outputs at reset values, no strobe; next frame 8'h3C is received correctly.
6. Frames 8'h00 and 8'hFF at BAUD ±3% -> correct Data_o, Done_o each frame, no FrameError_o.
